// File: rtl/qr_feeder.sv
// Buffers one ROWS x 4 signed matrix and streams it row by row into a QR array.
// Define QR_FEEDER_SKEW_EN to delay columns B/C/D by 1/2/3 cycles with a 3-cycle drain.
module qr_feeder #(
  parameter int ROWS  = 8,
  parameter int WIDTH = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic signed [WIDTH-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    qr_finish,
  output logic signed [WIDTH-1:0] data_outA,
  output logic signed [WIDTH-1:0] data_outB,
  output logic signed [WIDTH-1:0] data_outC,
  output logic signed [WIDTH-1:0] data_outD,
  output logic                    last_end,
  output logic                    out_valid,
  output logic                    frame_done
);

  localparam int NELEM = 4 * ROWS;
  localparam int IDXW  = $clog2(NELEM);
  localparam int RW    = $clog2(ROWS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NELEM - 1);
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STREAM    = 3'd2,
    DRAIN     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [IDXW-1:0]         elem_cnt_r;
  logic [RW-1:0]           row_cnt_r;
  logic [RW-1:0]           rd_row_s;
  logic [IDXW-1:0]         rd_base_s;
  logic                    accept_s;
  logic                    start_s;
  logic                    ready_r;
  logic                    valid_r;
  logic                    last_r;
  logic                    done_r;
  logic signed [WIDTH-1:0] buf_r [NELEM];
  logic signed [WIDTH-1:0] col_s [4];
  logic signed [WIDTH-1:0] col_r [4];

  assign accept_s = wr_en && ready_r;
  assign start_s  = (state_r == LOAD) && (state_s == STREAM);

  // Next-state logic for the load/stream/drain/wait sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = LOAD;
        else          state_s = IDLE;
      end
      LOAD: begin
        if (accept_s && (elem_cnt_r == LAST_IDX)) state_s = STREAM;
        else                                      state_s = LOAD;
      end
      STREAM: begin
        if (row_cnt_r == LAST_ROW) begin
`ifdef QR_FEEDER_SKEW_EN
          state_s = DRAIN;
`else
          state_s = WAIT_DONE;
`endif
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (row_cnt_r == RW'(2)) state_s = WAIT_DONE;
        else                     state_s = DRAIN;
      end
      WAIT_DONE: begin
        if (qr_finish) state_s = IDLE;
        else           state_s = WAIT_DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Row fetch: row 0 on stream entry, otherwise the row after the one on the outputs
  always_comb begin
    if (start_s) rd_row_s = '0;
    else         rd_row_s = row_cnt_r + RW'(1);
    rd_base_s = IDXW'({rd_row_s, 2'b00});
    for (int c = 0; c < 4; c++) begin
      col_s[c] = buf_r[rd_base_s + IDXW'(c)];
    end
  end

  // Element buffer; contents survive reset and are overwritten by the next frame
  always_ff @(posedge clk) begin
    if (accept_s && !reset) begin
      buf_r[elem_cnt_r] <= wr_data;
    end
  end

  // Control state, counters and column-A-aligned output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      elem_cnt_r <= '0;
      row_cnt_r  <= '0;
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      done_r     <= 1'b0;
      for (int c = 0; c < 4; c++) col_r[c] <= '0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE) || (state_s == LOAD);
      done_r  <= (state_r == WAIT_DONE) && qr_finish;
      if (accept_s) begin
        elem_cnt_r <= (elem_cnt_r == LAST_IDX) ? '0 : elem_cnt_r + IDXW'(1);
      end
      if (start_s) begin
        row_cnt_r <= '0;
      end else if (state_r == STREAM) begin
        row_cnt_r <= (row_cnt_r == LAST_ROW) ? '0 : row_cnt_r + RW'(1);
`ifdef QR_FEEDER_SKEW_EN
      end else if (state_r == DRAIN) begin
        row_cnt_r <= (row_cnt_r == RW'(2)) ? '0 : row_cnt_r + RW'(1);
`endif
      end
      if (start_s || ((state_r == STREAM) && (row_cnt_r != LAST_ROW))) begin
        for (int c = 0; c < 4; c++) col_r[c] <= col_s[c];
        valid_r <= 1'b1;
        last_r  <= (rd_row_s == LAST_ROW);
      end else begin
        for (int c = 0; c < 4; c++) col_r[c] <= '0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

`ifdef QR_FEEDER_SKEW_EN
  logic signed [WIDTH-1:0] b_d1_r, c_d1_r, c_d2_r, d_d1_r, d_d2_r, d_d3_r;

  // Skew delay lines for columns B, C and D
  always_ff @(posedge clk) begin
    if (reset) begin
      b_d1_r <= '0;
      c_d1_r <= '0;
      c_d2_r <= '0;
      d_d1_r <= '0;
      d_d2_r <= '0;
      d_d3_r <= '0;
    end else begin
      b_d1_r <= col_r[1];
      c_d1_r <= col_r[2];
      c_d2_r <= c_d1_r;
      d_d1_r <= col_r[3];
      d_d2_r <= d_d1_r;
      d_d3_r <= d_d2_r;
    end
  end

  assign data_outB = b_d1_r;
  assign data_outC = c_d2_r;
  assign data_outD = d_d3_r;
`else
  assign data_outB = col_r[1];
  assign data_outC = col_r[2];
  assign data_outD = col_r[3];
`endif

  assign data_outA  = col_r[0];
  assign wr_ready   = ready_r;
  assign out_valid  = valid_r;
  assign last_end   = last_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_qr_feeder.sv
// Self-checking bench for qr_feeder: schedule-based matrix model plus literal pins.
// Builds with or without QR_FEEDER_SKEW_EN.
module tb_qr_feeder;

  localparam int ROWS  = 4;
  localparam int WIDTH = 13;
  localparam int NEL   = 4 * ROWS;
`ifdef QR_FEEDER_SKEW_EN
  localparam int SK = 3;
`else
  localparam int SK = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset, wr_en, qr_finish;
  logic signed [WIDTH-1:0] wr_data;
  logic                    wr_ready, last_end, out_valid, frame_done;
  logic signed [WIDTH-1:0] data_outA, data_outB, data_outC, data_outD;

  qr_feeder #(.ROWS(ROWS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .qr_finish(qr_finish), .data_outA(data_outA), .data_outB(data_outB),
    .data_outC(data_outC), .data_outD(data_outD), .last_end(last_end),
    .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int mat [ROWS][4];
  int start_cyc = -1000;
  int kill_cyc  = 1 << 30;
  int done_cyc  = -1;
  bit chk_on    = 1'b0;
  int w;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
  endtask

  // Column c shows matrix row (cyc - start - skew_c); zero outside the frame or after an abort
  function automatic int exp_col(int c);
    int r;
    r = cyc - start_cyc - ((SK == 3) ? c : 0);
    if (cyc >= kill_cyc) return 0;
    if (r >= 0 && r < ROWS) return mat[r][c];
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      int r;
      bit live;
      r    = cyc - start_cyc;
      live = (cyc < kill_cyc);
      chk("out_valid",  out_valid,  32'(live && r >= 0 && r < ROWS));
      chk("last_end",   last_end,   32'(live && r == ROWS - 1));
      chk("data_outA",  data_outA,  exp_col(0));
      chk("data_outB",  data_outB,  exp_col(1));
      chk("data_outC",  data_outC,  exp_col(2));
      chk("data_outD",  data_outD,  exp_col(3));
      chk("frame_done", frame_done, 32'(cyc == done_cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic write_frame(input int base);
    for (int i = 0; i < NEL; i++) begin
      wr_en   = 1'b1;
      wr_data = WIDTH'(base + i);
      mat[i / 4][i % 4] = base + i;
      chk("wr_ready_load", wr_ready, 1);
      if (i == NEL - 1) begin
        start_cyc = cyc + 1;
        kill_cyc  = 1 << 30;
      end
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; qr_finish = 1'b0; wr_data = '0;
    step();
    chk_on = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("wr_ready_in_reset", wr_ready, 0);
    step();
    chk("wr_ready_after_reset", wr_ready, 1);

    // Frame A: 1..16, ignored writes of 99 and early qr_finish during stream
    write_frame(1);
    wr_en = 1'b1; wr_data = WIDTH'(99); qr_finish = 1'b1;
    w = start_cyc + ROWS + SK;
    while (cyc < w) begin
      chk("wr_ready_stream", wr_ready, 0);
      if (cyc == start_cyc) chk("pin_A_row0", data_outA, 1);
      if (cyc == start_cyc + ROWS - 1) begin
        chk("pin_A_last", data_outA, 13);
        chk("pin_last_end", last_end, 1);
      end
      if (cyc == start_cyc + SK / 3) chk("pin_B_first", data_outB, 2);
      if (cyc == start_cyc + ROWS - 1 + SK) chk("pin_D_last", data_outD, 16);
      step();
    end
    wr_en = 1'b0; qr_finish = 1'b0;
    wait_until(w + 5);
    chk("wr_ready_wait", wr_ready, 0);
    qr_finish = 1'b1; done_cyc = cyc + 1;
    step();
    qr_finish = 1'b0;
    chk("wr_ready_idle", wr_ready, 1);
    step();

    // Frame B: same data re-streamed, finish at first WAIT_DONE cycle
    write_frame(1);
    w = start_cyc + ROWS + SK;
    wait_until(w);
    qr_finish = 1'b1; done_cyc = cyc + 1;
    step();
    qr_finish = 1'b0;
    step();

    // Frame C back-to-back, aborted by reset after two streamed rows
    write_frame(101);
    step();
    reset = 1'b1; kill_cyc = cyc + 1;
    step();
    reset = 1'b0;
    step();
    chk("wr_ready_post_abort", wr_ready, 1);
    qr_finish = 1'b1;
    repeat (2) step();
    qr_finish = 1'b0;
    repeat (8) step();

    // Frame D: signed values -8..7
    write_frame(-8);
    w = start_cyc + ROWS + SK;
    wait_until(w + 1);
    qr_finish = 1'b1; done_cyc = cyc + 1;
    step();
    qr_finish = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
